// File: rtl/frame_tx_ctrl_pkg.sv
// Shared types and header helper for the frame transmit controller.
// Optional checksum trailer is enabled with the FRAME_TX_CSUM_EN macro.
package frame_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    BODY = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int HDR_LEN = 5;

  // Header layout: magic, width (big-endian), height (big-endian).
  function automatic byte_t hdr_byte(input logic [2:0] idx, input logic [15:0] w,
                                     input logic [15:0] h, input byte_t magic);
    byte_t b;
    case (idx)
      3'd0:    b = magic;
      3'd1:    b = w[15:8];
      3'd2:    b = w[7:0];
      3'd3:    b = h[15:8];
      3'd4:    b = h[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/frame_tx_ctrl_if.sv
// Byte-stream handshake bundle used on both sides of frame_tx_ctrl.
interface axis_if;
  import frame_pkg::*;

  // A byte moves only when vld & rdy are both high at the clock edge; while
  // vld is high and rdy low the source must hold data stable.
  logic  vld;
  logic  rdy;
  byte_t data;

  modport master (output vld, output data, input rdy);
  modport slave  (input vld, input data, output rdy);
endinterface

// File: rtl/frame_tx_ctrl_hdr_gen.sv
// Header byte sequencer: index register, header mux and last-byte flag.
module frame_hdr_gen
  import frame_pkg::*;
#(
  parameter int    WIDTH     = 640,
  parameter int    HEIGHT    = 480,
  parameter byte_t HDR_MAGIC = 8'hA5
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr_i,
  input  logic  adv_i,
  output byte_t data_o,
  output logic  last_o
);

  logic [2:0] hdr_idx_q;
  logic [2:0] hdr_idx_d;

  always_comb begin
    hdr_idx_d = hdr_idx_q;
    if (clr_i)
      hdr_idx_d = 3'd0;
    else if (adv_i)
      hdr_idx_d = hdr_idx_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hdr_idx_q <= 3'd0;
    else
      hdr_idx_q <= hdr_idx_d;
  end

  assign data_o = hdr_byte(hdr_idx_q, 16'(WIDTH), 16'(HEIGHT), HDR_MAGIC);
  assign last_o = (hdr_idx_q == 3'(HDR_LEN - 1));

endmodule

// File: rtl/frame_tx_ctrl.sv
// Frame sequencer: header, then exactly WIDTH*HEIGHT*3 gated body bytes, then done.
// Define FRAME_TX_CSUM_EN to append an XOR checksum byte after the body.
module frame_tx_ctrl
  import frame_pkg::*;
#(
  parameter int    WIDTH     = 640,
  parameter int    HEIGHT    = 480,
  parameter byte_t HDR_MAGIC = 8'hA5
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start,
  input  logic   abort,
  axis_if.slave  axis_i,
  axis_if.master axis_o,
  output logic   busy,
  output logic   done,
  output state_t state_o
);

  localparam longint unsigned TOTAL = 64'(WIDTH) * 64'(HEIGHT) * 64'd3;
  localparam int CNT_W = $clog2(TOTAL);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 64'd1);

  state_t           state_q;
  logic [CNT_W-1:0] byte_cnt_q;
  logic [CNT_W-1:0] byte_cnt_d;
  byte_t            hdr_data;
  logic             hdr_last;
  logic             ok;
  logic             hdr_clr;
  logic             hdr_adv;
`ifdef FRAME_TX_CSUM_EN
  byte_t            csum_q;
  byte_t            csum_d;
`endif

  assign ok         = axis_o.vld & axis_o.rdy;
  assign byte_cnt_d = byte_cnt_q + 1'b1;
  assign hdr_clr    = (state_q == IDLE) & start;
  assign hdr_adv    = (state_q == HDR) & ok;
`ifdef FRAME_TX_CSUM_EN
  assign csum_d     = csum_q ^ axis_i.data;
`endif

  frame_hdr_gen #(
    .WIDTH     (WIDTH),
    .HEIGHT    (HEIGHT),
    .HDR_MAGIC (HDR_MAGIC)
  ) u_hdr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (hdr_clr),
    .adv_i  (hdr_adv),
    .data_o (hdr_data),
    .last_o (hdr_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
`ifdef FRAME_TX_CSUM_EN
      csum_q     <= 8'h00;
`endif
    end else if (state_q == IDLE) begin
      // start beats a simultaneous abort here since abort only acts mid-frame
      if (start) begin
        state_q    <= HDR;
        byte_cnt_q <= '0;
`ifdef FRAME_TX_CSUM_EN
        csum_q     <= 8'h00;
`endif
      end
    end else if (abort) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        HDR: begin
          if (ok && hdr_last)
            state_q <= BODY;
        end
        BODY: begin
          if (ok) begin
            byte_cnt_q <= byte_cnt_d;
`ifdef FRAME_TX_CSUM_EN
            csum_q     <= csum_d;
            if (byte_cnt_q == LAST)
              state_q <= CSUM;
`else
            if (byte_cnt_q == LAST)
              state_q <= DONE;
`endif
          end
        end
`ifdef FRAME_TX_CSUM_EN
        CSUM: begin
          if (ok)
            state_q <= DONE;
        end
`endif
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode the state register only, except the body pass-through.
  always_comb begin
    axis_o.vld  = 1'b0;
    axis_o.data = 8'h00;
    axis_i.rdy  = 1'b0;
    case (state_q)
      HDR: begin
        axis_o.vld  = 1'b1;
        axis_o.data = hdr_data;
      end
      BODY: begin
        axis_o.vld  = axis_i.vld;
        axis_o.data = axis_i.data;
        axis_i.rdy  = axis_o.rdy;
      end
`ifdef FRAME_TX_CSUM_EN
      CSUM: begin
        axis_o.vld  = 1'b1;
        axis_o.data = csum_q;
      end
`endif
      default: ;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign state_o = state_q;

endmodule

// File: tb/tb_frame_tx_ctrl.sv
// Directed bench for frame_tx_ctrl with a 4x2 frame (24 body bytes).
module tb_frame_tx_ctrl;
  import frame_pkg::*;

  localparam int W      = 4;
  localparam int H      = 2;
  localparam int BODY_N = W * H * 3;
`ifdef FRAME_TX_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  typedef struct {
    bit tog;
    int up_len;
    int abort_after;
    int exp_up;
    int exp_tx;
    int exp_done;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   start = 1'b0;
  logic   abort = 1'b0;
  logic   busy;
  logic   done;
  state_t state;

  always #5 clk = ~clk;

  axis_if up_if ();
  axis_if tx_if ();

  frame_tx_ctrl #(
    .WIDTH     (W),
    .HEIGHT    (H),
    .HDR_MAGIC (8'hA5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .axis_i  (up_if.slave),
    .axis_o  (tx_if.master),
    .busy    (busy),
    .done    (done),
    .state_o (state)
  );

  // ---------------- scoreboard state ----------------
  int    n_pass  = 0;
  int    n_total = 0;
  byte_t rx_q[$];
  byte_t hdr_exp[5];
  int    up_ptr, up_len;
  int    done_cnt, done_cyc, last_ok_cyc, stable_viol;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver ----------------
  // Inputs change 1ns after posedge; DUT outputs are sampled on negedge.
  task automatic run_frame(input bit tog, input int len, input int abort_after,
                           input int restart_at, input int reset_at);
    int    cyc;
    bit    took, fired, pv, pr;
    byte_t pd;
    cyc = 0; fired = 0; pv = 0; pr = 0; pd = 8'h00;
    rx_q.delete();
    up_ptr = 0; up_len = len; done_cnt = 0; done_cyc = -1; last_ok_cyc = -1; stable_viol = 0;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0; tx_if.rdy = 1'b1;
    up_if.vld = (up_ptr < up_len); up_if.data = 8'(up_ptr);
    forever begin
      @(negedge clk);
      if (pv && !pr && (!tx_if.vld || tx_if.data != pd)) stable_viol++;
      pv = tx_if.vld; pr = tx_if.rdy; pd = tx_if.data;
      if (tx_if.vld && tx_if.rdy) begin
        rx_q.push_back(tx_if.data);
        last_ok_cyc = cyc;
      end
      took = up_if.vld && up_if.rdy;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cyc > 0 && !busy) break;
      if (cyc > 400) begin
        n_total++;
        $display("FAIL frame_timeout: busy still %0b after %0d cycles, required 0", busy, cyc);
        break;
      end
      @(posedge clk); #1;
      cyc++;
      start = 1'b0; abort = 1'b0;
      if (took) up_ptr++;
      tx_if.rdy = tog ? ~tx_if.rdy : 1'b1;
      up_if.vld = (up_ptr < up_len); up_if.data = 8'(up_ptr);
      if (!fired && abort_after >= 0 && up_ptr == abort_after) begin
        abort = 1'b1; fired = 1;
      end
      if (!fired && restart_at >= 0 && up_ptr == restart_at) begin
        start = 1'b1; fired = 1;
      end
      if (!fired && reset_at >= 0 && up_ptr == reset_at) begin
        fired = 1;
        #3 rst_n = 1'b0;
        #1 break;
      end
    end
  endtask

  task automatic verify(input string tag, input int exp_up, input int exp_done, input int exp_tx);
    byte_t e;
    check({tag, " up_taken"}, up_ptr, exp_up);
    check({tag, " tx_len"}, rx_q.size(), exp_tx);
    check({tag, " done_pulses"}, done_cnt, exp_done);
    check({tag, " hold_stable_violations"}, stable_viol, 0);
    for (int i = 0; i < rx_q.size() && i < exp_tx; i++) begin
      if (i < 5) e = hdr_exp[i];
      else if (i < 5 + BODY_N) e = 8'(i - 5);
      else e = 8'h00;  // XOR of 0x00..0x17
      check($sformatf("%s tx_byte%0d", tag, i), rx_q[i], e);
    end
    if (exp_done > 0) check({tag, " done_timing"}, done_cyc, last_ok_cyc + 1);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[5];

  initial begin
    hdr_exp[0] = 8'hA5; hdr_exp[1] = 8'h00; hdr_exp[2] = 8'h04;
    hdr_exp[3] = 8'h00; hdr_exp[4] = 8'h02;
    //            tog up_len abort exp_up exp_tx            exp_done
    vecs[0] = '{1'b0, 24, -1, 24, 5 + BODY_N + CS, 1};
    vecs[1] = '{1'b1, 24, -1, 24, 5 + BODY_N + CS, 1};
    vecs[2] = '{1'b0, 30, -1, 24, 5 + BODY_N + CS, 1};
    vecs[3] = '{1'b0, 30, 10, 11, 16,              0};
    vecs[4] = '{1'b0, 24, -1, 24, 5 + BODY_N + CS, 1};

    tx_if.rdy = 1'b1; up_if.vld = 1'b0; up_if.data = 8'h00;
    #2;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset tx_vld", tx_if.vld, 0);
    check("reset up_rdy", up_if.rdy, 0);
    check("reset state", state, IDLE);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle no start busy", busy, 0);

    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].tog, vecs[v].up_len, vecs[v].abort_after, -1, -1);
      verify($sformatf("vec%0d", v), vecs[v].exp_up, vecs[v].exp_done, vecs[v].exp_tx);
    end

    // start during BODY must not queue a second frame
    run_frame(1'b0, 24, -1, 5, -1);
    verify("restart_ignored", 24, 1, 5 + BODY_N + CS);
    repeat (10) @(negedge clk);
    check("restart_ignored stays_idle", busy, 0);

    // asynchronous reset mid-body
    run_frame(1'b0, 30, -1, -1, 8);
    check("midreset tx_vld", tx_if.vld, 0);
    check("midreset up_rdy", up_if.rdy, 0);
    check("midreset busy", busy, 0);
    check("midreset state", state, IDLE);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("postreset busy", busy, 0);
    check("postreset tx_vld", tx_if.vld, 0);

    run_frame(1'b0, 24, -1, -1, -1);
    verify("postreset_frame", 24, 1, 5 + BODY_N + CS);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/frame_tx_ctrl.md
Name: frame_tx_ctrl

Overview:
- Sequences one filtered frame onto the outbound byte stream (UART TX side).
- Sits downstream of the chunk-to-byte serializer. On `start` it emits a fixed header, then gates exactly WIDTH*HEIGHT*3 pixel bytes through from the serializer, then returns to idle.
- Upstream is held off (rdy low) outside the body phase, so the filter pipeline stalls between frames.

Parameters:
- WIDTH, 640, frame width in pixels, 1..65535
- HEIGHT, 480, frame height in pixels, 1..65535
- HDR_MAGIC, 8'hA5, first header byte

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- start  input  1  single-cycle request to send one frame; honoured only in IDLE
- abort  input  1  synchronous; drops the current frame, returns to IDLE
- axis_i  axis_if.slave  8-bit data  RGB bytes from the serializer
- axis_o  axis_if.master  8-bit data  bytes to TX
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the last byte of a frame is accepted

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values (rst_n low, takes effect immediately):
  - state=IDLE, axis_o.vld=0, axis_i.rdy=0, busy=0, done=0
  - counters 0, checksum 0
- Handshake: ok = vld & rdy. A byte transfers only on ok. While vld=1 and rdy=0, data is held stable.
- FSM states: IDLE, HDR, BODY, CSUM (only when the feature is compiled in), DONE.
- IDLE:
  - axis_o.vld=0, axis_i.rdy=0.
  - start=1 moves to HDR next cycle and clears hdr_idx, byte_cnt and checksum.
- HDR:
  - axis_i.rdy=0, axis_o.vld=1.
  - axis_o.data by hdr_idx: 0 → HDR_MAGIC, 1 → WIDTH[15:8], 2 → WIDTH[7:0], 3 → HEIGHT[15:8], 4 → HEIGHT[7:0].
  - hdr_idx increments on axis_o.ok. Leaving index 4 on ok moves to BODY.
  - No bubble between header and body beyond the state change.
- BODY: combinational pass-through.
  - axis_o.vld=axis_i.vld, axis_o.data=axis_i.data, axis_i.rdy=axis_o.rdy.
  - byte_cnt increments on ok. Counter width is $clog2(WIDTH*HEIGHT*3).
  - ok with byte_cnt==WIDTH*HEIGHT*3-1 moves to CSUM if enabled, else DONE.
  - Bytes beyond the frame total are never accepted: rdy is low after the transition.
- DONE: done=1 for one cycle, busy still 1; IDLE next cycle.
- start outside IDLE is ignored. It is not queued.
- abort in any non-IDLE state:
  - Next state is IDLE; done is not pulsed.
  - axis_o.vld and axis_i.rdy drop in the following cycle.
  - If abort and ok fall in the same cycle, the byte counts as transferred but the frame still aborts.
  - abort and start in the same cycle while in IDLE: start wins.
- Latency: start → first header vld is 1 cycle. Body adds 0 cycles of latency.
- Reset mid-frame: the frame is dropped and upstream content is not flushed. Upstream clearing is the top level's responsibility.

Optional Feature:
- Macro: FRAME_TX_CSUM_EN.
- Defined:
  - checksum register = XOR of every body byte, updated on ok in BODY.
  - CSUM state drives axis_o.vld=1, data=checksum, axis_i.rdy=0. ok moves to DONE.
  - Total frame length = 5 + W*H*3 + 1.
- Undefined: no CSUM state, no checksum register; BODY goes straight to DONE.

Decomposition:
- frame_pkg:
  - byte_t (logic [7:0])
  - state_t enum {IDLE, HDR, BODY, CSUM, DONE}
  - HDR_LEN=5
  - function hdr_byte(idx, w, h, magic) → byte_t
- Sub-module frame_hdr_gen: holds hdr_idx, drives the header byte mux, and produces last_hdr. It advances on an `adv` input. All other logic stays in frame_tx_ctrl.

Test Plan (WIDTH=4, HEIGHT=2 → 24 body bytes; TX rdy always 1 unless stated):
- start pulse, body bytes 0x00..0x17 → TX sees A5 00 04 00 02 00..17; done pulses 1 cycle after byte 0x17; 29 bytes total.
- TX rdy toggled 1/0 every cycle during header → each header byte held stable while rdy=0; exactly 5 header bytes, no duplicates.
- Upstream presents 30 bytes → only 24 accepted; axis_i.rdy=0 from the cycle after the 24th ok; remaining 6 bytes stay upstream.
- abort asserted after body byte 10 → IDLE next cycle, done never pulses; a new start re-emits the header A5 00 04 00 02.
- start pulsed during BODY, and rst_n pulsed low mid-body → second start ignored (single frame); on reset, vld/busy go 0 immediately and IDLE is held until the next start.
- FRAME_TX_CSUM_EN with body 0x00..0x17 → byte after 0x17 is 0x00 (XOR of 0..23), then done; 30 bytes total.
